// File: rtl/led_pkg.sv
// led_pkg: shared constants and helpers for the LED bar-graph peak driver.
//   MODE_BAR / MODE_DOT : values of the display-mode input.
//   PWM_BITS            : width of the brightness input and PWM counter.
//   level_width()       : number of bits needed to index one of n LEDs.
package led_pkg;

    localparam logic MODE_BAR = 1'b0;
    localparam logic MODE_DOT = 1'b1;
    localparam int   PWM_BITS = 4;

    function automatic int level_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/led_bargraph_peak_if.sv
// led_bargraph_peak_if: sample/control bundle between the meter datapath
// (master) and the LED driver (slave).
//   sample, sample_valid, mode : master -> slave
//   brightness                 : master -> slave, only with LED_PWM_DIM_EN
//   led, peak_level            : slave -> master
interface led_bargraph_peak_if #(
    parameter int IN_WIDTH = 8,
    parameter int NLEDS    = 8
) ();
    import led_pkg::*;

    localparam int LW = level_width(NLEDS);

    logic [IN_WIDTH-1:0] sample;
    logic                sample_valid;
    logic                mode;
`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] brightness;
`endif
    logic [NLEDS-1:0]    led;
    logic [LW-1:0]       peak_level;

`ifdef LED_PWM_DIM_EN
    modport master (output sample, sample_valid, mode, brightness, input led, peak_level);
    modport slave  (input sample, sample_valid, mode, brightness, output led, peak_level);
`else
    modport master (output sample, sample_valid, mode, input led, peak_level);
    modport slave  (input sample, sample_valid, mode, output led, peak_level);
`endif

endinterface

// File: rtl/led_thermo_enc.sv
// led_thermo_enc: combinational level -> LED pattern encoder.
//   level   : index of the top lit LED (0 lights LED0)
//   mode    : MODE_BAR lights 0..level, MODE_DOT lights only bit level
//   pattern : NLEDS-wide LED pattern, bit 0 is the lowest LED
module led_thermo_enc #(
    parameter int NLEDS = 8,
    parameter int LW    = 3
) (
    input  logic [LW-1:0]    level,
    input  logic             mode,
    output logic [NLEDS-1:0] pattern
);
    import led_pkg::*;

    // Per-LED compare against the level, shape chosen by mode
    always_comb begin
        pattern = {NLEDS{1'b0}};
        for (int i = 0; i < NLEDS; i++) begin
            case (mode)
                MODE_BAR: pattern[i] = (LW'(i) <= level);
                MODE_DOT: pattern[i] = (LW'(i) == level);
                default:  pattern[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_bargraph_peak.sv
// led_bargraph_peak: LED bar-graph / dot driver with peak-hold marker.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_bargraph_peak_if.slave (sample, sample_valid, mode,
//                brightness when LED_PWM_DIM_EN is defined; led, peak_level)
// The peak marker holds HOLD_CYCLES after being set or re-armed, then steps
// down one LED every DECAY_CYCLES until it meets the current level.
// Optional feature macro LED_PWM_DIM_EN: PWM-dims the bar/dot pattern by the
// 4-bit brightness input while the peak marker stays at full duty.
module led_bargraph_peak #(
    parameter int IN_WIDTH     = 8,
    parameter int NLEDS        = 8,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int DECAY_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    led_bargraph_peak_if.slave bus
);
    import led_pkg::*;

    localparam int LW   = level_width(NLEDS);
    localparam int CMAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DECAY_LOAD = CW'(DECAY_CYCLES - 1);

    logic [LW-1:0]    cur_level_r, peak_r;
    logic [LW-1:0]    new_level_s, cur_nxt_s, peak_nxt_s;
    logic [CW-1:0]    hold_cnt_r, hold_nxt_s;
    logic             seen_r, seen_nxt_s;
    logic [NLEDS-1:0] led_r, led_nxt_s, pat_s, pat_gated_s, marker_s;

    // Next-state for level, peak and hold timer in priority order
    always_comb begin
        new_level_s = LW'(bus.sample >> (IN_WIDTH - LW));
        cur_nxt_s   = cur_level_r;
        seen_nxt_s  = seen_r;
        peak_nxt_s  = peak_r;
        hold_nxt_s  = hold_cnt_r;
        if (bus.sample_valid) begin
            cur_nxt_s  = new_level_s;
            seen_nxt_s = 1'b1;
        end else begin
            cur_nxt_s  = cur_level_r;
            seen_nxt_s = seen_r;
        end
        // Decay compares against the registered level; a lower sample on the
        // same cycle only lowers cur_level, so peak >= cur_level still holds.
        if (bus.sample_valid && (new_level_s >= peak_r)) begin
            peak_nxt_s = new_level_s;
            hold_nxt_s = HOLD_LOAD;
        end else if (hold_cnt_r != {CW{1'b0}}) begin
            hold_nxt_s = hold_cnt_r - CW'(1);
        end else if (peak_r > cur_level_r) begin
            peak_nxt_s = peak_r - LW'(1);
            hold_nxt_s = DECAY_LOAD;
        end else begin
            peak_nxt_s = peak_r;
            hold_nxt_s = hold_cnt_r;
        end
    end

    led_thermo_enc #(
        .NLEDS (NLEDS),
        .LW    (LW)
    ) u_enc (
        .level   (cur_nxt_s),
        .mode    (bus.mode),
        .pattern (pat_s)
    );

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt_r;

    // Free-running PWM phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end
`endif

    // Pattern dimming and composition with the full-duty peak marker
    always_comb begin
        marker_s = {{(NLEDS-1){1'b0}}, 1'b1} << peak_nxt_s;
`ifdef LED_PWM_DIM_EN
        if (pwm_cnt_r < bus.brightness) begin
            pat_gated_s = pat_s;
        end else begin
            pat_gated_s = {NLEDS{1'b0}};
        end
`else
        pat_gated_s = pat_s;
`endif
        if (seen_nxt_s) begin
            led_nxt_s = pat_gated_s | marker_s;
        end else begin
            led_nxt_s = {NLEDS{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_level_r <= {LW{1'b0}};
            peak_r      <= {LW{1'b0}};
            hold_cnt_r  <= {CW{1'b0}};
            seen_r      <= 1'b0;
            led_r       <= {NLEDS{1'b0}};
        end else begin
            cur_level_r <= cur_nxt_s;
            peak_r      <= peak_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            seen_r      <= seen_nxt_s;
            led_r       <= led_nxt_s;
        end
    end

    assign bus.led        = led_r;
    assign bus.peak_level = peak_r;

endmodule

// File: tb/tb_led_bargraph_peak.sv
// tb_led_bargraph_peak: self-checking bench for led_bargraph_peak
// (IN_WIDTH=8, NLEDS=8, HOLD_CYCLES=4, DECAY_CYCLES=2). Uses a vector
// table, hand-written corner sequences and random stimulus against a
// timestamp-based reference model.
module tb_led_bargraph_peak;

    localparam int HOLD  = 4;
    localparam int DECAY = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    led_bargraph_peak_if #(.IN_WIDTH(8), .NLEDS(8)) bus ();

    led_bargraph_peak #(
        .IN_WIDTH     (8),
        .NLEDS        (8),
        .HOLD_CYCLES  (HOLD),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: peak falls one step whenever the current cycle has
    // reached a deadline (arm time + HOLD, or last step + DECAY) and the peak
    // is still above the level that was displayed.
    int        m_cyc = 0;
    int        m_deadline = 0;
    int        m_cur = 0;
    int        m_peak = 0;
    bit        m_seen = 0;
    int        m_pwm = 0;
    bit        m_gate = 1;
    logic [7:0] m_led = 8'h00;

    task automatic model_reset();
        m_cur = 0; m_peak = 0; m_seen = 0; m_pwm = 0;
        m_deadline = m_cyc; m_led = 8'h00; m_gate = 1;
    endtask

    task automatic model_step();
        int lvl, cur_old, pat, bright;
        lvl     = int'(bus.sample) / 32;
        cur_old = m_cur;
`ifdef LED_PWM_DIM_EN
        bright  = int'(bus.brightness);
`else
        bright  = 16;
`endif
        m_gate = (m_pwm < bright);
        m_pwm  = (m_pwm + 1) % 16;
        if (bus.sample_valid) begin
            m_seen = 1;
            m_cur  = lvl;
        end
        if (bus.sample_valid && lvl >= m_peak) begin
            m_peak = lvl;
            m_deadline = m_cyc + HOLD;
        end else if (m_cyc >= m_deadline && m_peak > cur_old) begin
            m_peak = m_peak - 1;
            m_deadline = m_cyc + DECAY;
        end
        if (bus.mode) pat = 1 << m_cur;
        else          pat = (1 << (m_cur + 1)) - 1;
        if (!m_gate) pat = 0;
        m_led = m_seen ? 8'(pat | (1 << m_peak)) : 8'h00;
        m_cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp_model(input string nm);
        check({nm, "_led"}, 32'(bus.led), 32'(m_led));
        check({nm, "_peak"}, 32'(bus.peak_level), 32'(m_peak));
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic md);
        bus.sample_valid = v;
        bus.sample       = s;
        bus.mode         = md;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       m;
        logic [7:0] led;
        logic [2:0] pk;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] adj;
        int lit_cnt;

        drive(1'b0, 8'h00, 1'b0);
`ifdef LED_PWM_DIM_EN
        bus.brightness = 4'd15;
`endif
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check("reset_led", 32'(bus.led), 32'h0);
        check("reset_peak", 32'(bus.peak_level), 32'h0);
        tick();
        check("pre_sample_led", 32'(bus.led), 32'h0);

        // Basic levels, then a full-scale sample followed by a zero sample
        tbl.push_back('{1'b1, 8'h00, 1'b0, 8'h01, 3'd0});
        tbl.push_back('{1'b1, 8'h5F, 1'b0, 8'h07, 3'd2});
        tbl.push_back('{1'b1, 8'hFF, 1'b0, 8'hFF, 3'd7});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 8'h81, 3'd7});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h81, 3'd7});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h81, 3'd7});
        for (int k = 6; k >= 1; k--) begin
            for (int r = 0; r < 2; r++) begin
                tbl.push_back('{1'b0, 8'h00, 1'b0, 8'((1 << k) | 1), 3'(k)});
            end
        end
        for (int r = 0; r < 3; r++) tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h01, 3'd0});

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].m);
            tick();
            adj = m_gate ? tbl[i].led : (tbl[i].led & (8'h01 << tbl[i].pk));
            check($sformatf("tbl%0d_led", i), 32'(bus.led), 32'(adj));
            check($sformatf("tbl%0d_peak", i), 32'(bus.peak_level), 32'(tbl[i].pk));
            cmp_model($sformatf("tbl%0d_model", i));
        end

        // Re-arm during hold at peak 7
        drive(1'b1, 8'hFF, 1'b0); tick(); cmp_model("rearm_a");
        drive(1'b1, 8'h00, 1'b0); tick(); cmp_model("rearm_b");
        drive(1'b1, 8'hE0, 1'b0); tick(); cmp_model("rearm_c");
        drive(1'b1, 8'h00, 1'b0);
        for (int r = 0; r < 3; r++) begin
            tick();
            check("rearm_hold_peak", 32'(bus.peak_level), 32'd7);
            cmp_model("rearm_hold");
            drive(1'b0, 8'h00, 1'b0);
        end
        tick();
        check("rearm_expire_peak", 32'(bus.peak_level), 32'd6);
        cmp_model("rearm_expire");
        // Decay to peak 5, then a level-5 sample restarts the hold
        while (m_peak > 5) begin tick(); cmp_model("decay_to5"); end
        drive(1'b1, 8'hA0, 1'b0); tick(); cmp_model("eq_rearm");
        drive(1'b1, 8'h00, 1'b0);
        for (int r = 0; r < 3; r++) begin
            tick();
            check("eq_hold_peak", 32'(bus.peak_level), 32'd5);
            drive(1'b0, 8'h00, 1'b0);
        end
        tick();
        check("eq_expire_peak", 32'(bus.peak_level), 32'd4);

        // Dot mode, then switch back to bar without a sample
        drive(1'b1, 8'hC0, 1'b0); tick(); cmp_model("dot_a");
        drive(1'b1, 8'h5F, 1'b1); tick();
        if (m_gate) check("dot_led", 32'(bus.led), 32'h44);
        cmp_model("dot_b");
        drive(1'b0, 8'h00, 1'b0); tick();
        if (m_gate) check("bar_switch_led", 32'(bus.led), 32'h47);
        cmp_model("bar_switch");

        // Asynchronous reset mid-decay
        drive(1'b1, 8'hFF, 1'b0); tick();
        drive(1'b1, 8'h00, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        for (int r = 0; r < 5; r++) tick();
        cmp_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led), 32'h0);
        check("async_rst_peak", 32'(bus.peak_level), 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            check("post_rst_led", 32'(bus.led), 32'h0);
        end

`ifdef LED_PWM_DIM_EN
        bus.brightness = 4'd4;
        drive(1'b1, 8'hC0, 1'b0); tick();
        drive(1'b1, 8'h5F, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        lit_cnt = 0;
        for (int r = 0; r < 32; r++) begin
            tick();
            if (bus.led[1:0] == 2'b11) lit_cnt++;
            check("pwm_marker", 32'(bus.led[bus.peak_level]), 32'h1);
            cmp_model("pwm");
        end
        check("pwm_duty", 32'(lit_cnt), 32'd8);
        bus.brightness = 4'd0;
        drive(1'b1, 8'hC0, 1'b0); tick();
        drive(1'b1, 8'h5F, 1'b0); tick();
        check("pwm_off_led", 32'(bus.led), 32'h40);
        bus.brightness = 4'd15;
`else
        lit_cnt = 0;
`endif

        // Random stimulus against the reference model
        for (int r = 0; r < 400; r++) begin
            drive(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
`ifdef LED_PWM_DIM_EN
            bus.brightness = 4'($urandom_range(0, 15));
`endif
            tick();
            cmp_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_bargraph_peak.md
Name: led_bargraph_peak

Overview:
Parametrised LED bar-graph driver. It converts an IN_WIDTH-bit magnitude sample into an NLEDS-wide thermometer (bar) or single-dot display. It adds a peak-hold marker that holds for HOLD_CYCLES and then decays one LED per DECAY_CYCLES. It sits between the sampled-value source (ADC/meter datapath) and the board LED pins, and its outputs are registered.

Parameters:
- IN_WIDTH, 8, sample width in bits; must be at least log2(NLEDS).
- NLEDS, 8, number of LEDs; power of 2, 2..2^IN_WIDTH.
- HOLD_CYCLES, 50_000_000, clk cycles the peak is held after being set or re-armed; at least 1.
- DECAY_CYCLES, 5_000_000, clk cycles per one-LED peak decrement after the hold expires; at least 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample  input  IN_WIDTH  unsigned magnitude.
- sample_valid  input  1  single-cycle strobe; sample is captured when high.
- mode  input  1  0 = bar mode, 1 = dot mode.
- led  output  NLEDS  LED drive; bit 0 is the lowest LED.
- peak_level  output  log2(NLEDS)  current peak index, for debug/status.

Behaviour:
- Level is computed as level = sample >> (IN_WIDTH - log2(NLEDS)), i.e. truncation. There is no rounding.
- The level register (cur_level) loads on sample_valid and holds otherwise.
- Bar pattern: bits 0..cur_level set. Level 0 lights LED0.
- Dot pattern: only bit cur_level set.
- Output is led = pattern OR onehot(peak), registered.
- Latency: led reflects a sample on the first clk edge after the sample_valid cycle, i.e. 1 cycle.
- mode is sampled every cycle and is not latched with the sample.
- Peak/hold logic, evaluated each cycle in priority order:
  1. sample_valid and new level >= peak: peak <= new level; hold_cnt <= HOLD_CYCLES-1. A level equal to the peak re-arms the hold.
  2. Else if hold_cnt != 0: hold_cnt decrements.
  3. Else if peak > cur_level: peak decrements; hold_cnt <= DECAY_CYCLES-1.
  4. Else (peak == cur_level): idle.
- Invariant: peak >= cur_level at all times.
- A new sample arriving mid-decay takes priority over decay on the same cycle.
- A lower sample never lowers the peak directly.
- Reset values (immediate on rst_n low, asynchronous): led = 0 (all off), peak_level = 0, cur_level = 0, hold_cnt = 0, internal state all 0.
- led stays 0 after reset until the first sample_valid.
- Reset mid-hold or mid-decay discards all state.
- hold_cnt width is clog2(max(HOLD_CYCLES, DECAY_CYCLES)). It never wraps, because it only decrements while non-zero.

Optional Feature:
- Macro: LED_PWM_DIM_EN.
- When defined:
  - Adds input brightness [3:0] and a free-running 4-bit PWM counter that resets to 0.
  - Bar/dot pattern bits are forced off when pwm_cnt >= brightness, so brightness 0 means pattern off and 15 means 15/16 duty.
  - The peak marker bit is always driven at full duty.
  - brightness is sampled every cycle.
- When undefined: no brightness port, no PWM counter, pattern always at full duty.

Decomposition:
- Package led_pkg holds:
  - MODE_BAR = 1'b0 and MODE_DOT = 1'b1 constants.
  - A level-width function log2(NLEDS).
  - PWM_BITS = 4.
- Sub-module led_thermo_enc (combinational): level plus mode in, NLEDS pattern out. It is instantiated once; the top holds all registers and counters.

Test Plan:
All cases use IN_WIDTH=8, NLEDS=8, HOLD_CYCLES=4, DECAY_CYCLES=2, mode=0 unless noted.
1. Reset, then samples 0x00, 0x5F, 0xFF, each with a 1-cycle valid -> led = 0x00 before the first sample, then 0x01, then 0x07 with peak 2, then 0xFF.
2. Sample 0xFF, then 0x00 on the next cycle -> led 0xFF for 1 cycle, then 0x81 until the 4-cycle hold expires, then 0x41 for 2 cycles, then 0x21 for 2 cycles, and so on down to 0x01. peak_level ends at 0 and stays.
3. During the hold at peak 7, sample 0xE0 (level 7) -> hold re-armed: 0x81 persists 4 cycles from the re-arm. During decay at peak 5, sample 0xA0 (level 5) -> peak stays 5 and the hold restarts.
4. mode=1, sample 0x5F after the peak was 6 -> led = 0x44; switch mode to 0 without a new sample -> led = 0x47 on the next cycle.
5. Reset mid-decay: drive rst_n low asynchronously between edges -> led and peak_level go to 0 without waiting for a clk edge and stay 0 after release until the next sample_valid.
6. LED_PWM_DIM_EN defined, brightness = 4, steady sample 0x5F with peak 6 -> bits 0..2 high for 4 of every 16 cycles, bit 6 high continuously. brightness = 0 -> only 0x40.
